// File: rtl/i2c_bus_monitor.sv
// i2c_bus_monitor
// Decodes I2C bus events from the debounced SCL/SDA levels: START, repeated
// START, STOP, SCL edges, received bytes (MSB first) and the ACK bit.
// All outputs are registered; every pulse is one fastClock cycle wide and
// appears one edge after the input transition is first sampled.
//
// Optional feature: define BUS_TIMEOUT_EN to enable the SCL-low bus timeout
// (TIMEOUT_CYCLES). Without it busTimeout is tied low and no counter exists.
//
// Handshake: there is no back-pressure. Each *Valid / *Detected output is a
// single-cycle strobe and its qualifying data (byteData, byteIsAddress,
// ackBit) is valid in that same cycle; consumers must take it then.
//
// dbgState exposes the receive FSM (0 = IDLE, 1 = DATA, 2 = ACK).

module i2c_bus_monitor #(
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic       fastClock,
    input  logic       resetN,
    input  logic       sclIn,
    input  logic       sdaIn,
    output logic       startDetected,
    output logic       repStartDetected,
    output logic       stopDetected,
    output logic       sclRise,
    output logic       sclFall,
    output logic       busBusy,
    output logic [7:0] byteData,
    output logic       byteValid,
    output logic       byteIsAddress,
    output logic       ackBit,
    output logic       ackValid,
    output logic       frameError,
    output logic       busTimeout,
    output logic [1:0] dbgState
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    // The timeout counter is 16 bits wide, so the limit must fit it.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..65535");
    end

    state_t      state_q, state_d;
    logic        scl_q, sda_q;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [6:0]  shift_q, shift_d;
    logic        addr_flag_q, addr_flag_d;
    logic        busy_q, busy_d;
    logic [7:0]  byte_data_q, byte_data_d;
    logic        ack_bit_q, ack_bit_d;

    logic        start_q, rep_start_q, stop_q, rise_q, fall_q;
    logic        byte_valid_q, byte_valid_d;
    logic        byte_is_addr_q, byte_is_addr_d;
    logic        ack_valid_q, ack_valid_d;
    logic        frame_err_q, frame_err_d;

    logic        scl_rise, scl_fall, start_cond, stop_cond;
    logic        to_fire;

    // Bus conditions from previous vs. current sample. START/STOP need SCL
    // stable high, so a simultaneous SCL+SDA change only yields an SCL edge.
    always_comb begin
        scl_rise   = ~scl_q & sclIn;
        scl_fall   = scl_q & ~sclIn;
        start_cond = scl_q & sclIn & sda_q & ~sdaIn;
        stop_cond  = scl_q & sclIn & ~sda_q & sdaIn;
    end

`ifdef BUS_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

    logic [15:0] to_cnt_q, to_cnt_d, to_cnt_inc;
    logic        timeout_q;

    // Count cycles with SCL low while busy; fire when the count hits the limit.
    always_comb begin
        to_cnt_inc = to_cnt_q + 16'd1;
        to_cnt_d   = '0;
        to_fire    = 1'b0;
        if (busy_q && !sclIn) begin
            if (to_cnt_inc == TIMEOUT_LIMIT) begin
                to_fire = 1'b1;
            end else begin
                to_cnt_d = to_cnt_inc;
            end
        end
    end

    // Timeout counter and its registered pulse.
    always_ff @(posedge fastClock or negedge resetN) begin
        if (!resetN) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            timeout_q <= to_fire;
        end
    end

    assign busTimeout = timeout_q;
`else
    assign to_fire    = 1'b0;
    assign busTimeout = 1'b0;
`endif

    // Next-state logic: START/STOP/timeout override everything, otherwise
    // SCL rises shift data bits (DATA) or sample the ACK bit (ACK).
    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        shift_d        = shift_q;
        addr_flag_d    = addr_flag_q;
        busy_d         = busy_q;
        byte_data_d    = byte_data_q;
        ack_bit_d      = ack_bit_q;
        byte_valid_d   = 1'b0;
        byte_is_addr_d = 1'b0;
        ack_valid_d    = 1'b0;
        frame_err_d    = 1'b0;

        if (start_cond) begin
            // Any partial byte is dropped silently; the next byte is an address.
            state_d     = ST_DATA;
            bit_cnt_d   = 3'd0;
            shift_d     = '0;
            addr_flag_d = 1'b1;
            busy_d      = 1'b1;
        end else if (stop_cond) begin
            frame_err_d = (state_q == ST_ACK) ||
                          ((state_q == ST_DATA) && (bit_cnt_q != 3'd0));
            state_d     = ST_IDLE;
            bit_cnt_d   = 3'd0;
            shift_d     = '0;
            addr_flag_d = 1'b0;
            busy_d      = 1'b0;
        end else if (to_fire) begin
            state_d     = ST_IDLE;
            bit_cnt_d   = 3'd0;
            shift_d     = '0;
            addr_flag_d = 1'b0;
            busy_d      = 1'b0;
        end else if (scl_rise) begin
            unique case (state_q)
                ST_DATA: begin
                    shift_d   = {shift_q[5:0], sdaIn};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        byte_data_d    = {shift_q, sdaIn};
                        byte_valid_d   = 1'b1;
                        byte_is_addr_d = addr_flag_q;
                        addr_flag_d    = 1'b0;
                        state_d        = ST_ACK;
                    end
                end
                ST_ACK: begin
                    ack_bit_d   = sdaIn;
                    ack_valid_d = 1'b1;
                    state_d     = ST_DATA;
                end
                default: begin
                end
            endcase
        end
    end

    // State, input history and registered outputs.
    always_ff @(posedge fastClock or negedge resetN) begin
        if (!resetN) begin
            state_q        <= ST_IDLE;
            scl_q          <= 1'b1;
            sda_q          <= 1'b1;
            bit_cnt_q      <= 3'd0;
            shift_q        <= '0;
            addr_flag_q    <= 1'b0;
            busy_q         <= 1'b0;
            byte_data_q    <= 8'h00;
            ack_bit_q      <= 1'b0;
            start_q        <= 1'b0;
            rep_start_q    <= 1'b0;
            stop_q         <= 1'b0;
            rise_q         <= 1'b0;
            fall_q         <= 1'b0;
            byte_valid_q   <= 1'b0;
            byte_is_addr_q <= 1'b0;
            ack_valid_q    <= 1'b0;
            frame_err_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            scl_q          <= sclIn;
            sda_q          <= sdaIn;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            addr_flag_q    <= addr_flag_d;
            busy_q         <= busy_d;
            byte_data_q    <= byte_data_d;
            ack_bit_q      <= ack_bit_d;
            start_q        <= start_cond;
            rep_start_q    <= start_cond & busy_q;
            stop_q         <= stop_cond;
            rise_q         <= scl_rise;
            fall_q         <= scl_fall;
            byte_valid_q   <= byte_valid_d;
            byte_is_addr_q <= byte_is_addr_d;
            ack_valid_q    <= ack_valid_d;
            frame_err_q    <= frame_err_d;
        end
    end

    assign startDetected    = start_q;
    assign repStartDetected = rep_start_q;
    assign stopDetected     = stop_q;
    assign sclRise          = rise_q;
    assign sclFall          = fall_q;
    assign busBusy          = busy_q;
    assign byteData         = byte_data_q;
    assign byteValid        = byte_valid_q;
    assign byteIsAddress    = byte_is_addr_q;
    assign ackBit           = ack_bit_q;
    assign ackValid         = ack_valid_q;
    assign frameError       = frame_err_q;
    assign dbgState         = state_q;

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// Testbench for i2c_bus_monitor: directed bus sequences, a transaction-level
// model checked every cycle, and literal expectations on key results.
module tb_i2c_bus_monitor;

    localparam int TO_LIM = 100;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic scl = 1'b1;
    logic sda = 1'b1;

    always #5 clk = ~clk;

    logic       startDetected, repStartDetected, stopDetected;
    logic       sclRise, sclFall, busBusy;
    logic [7:0] byteData;
    logic       byteValid, byteIsAddress, ackBit, ackValid;
    logic       frameError, busTimeout;
    logic [1:0] dbgState;

    i2c_bus_monitor #(.TIMEOUT_CYCLES(TO_LIM)) dut (
        .fastClock       (clk),
        .resetN          (rst_n),
        .sclIn           (scl),
        .sdaIn           (sda),
        .startDetected   (startDetected),
        .repStartDetected(repStartDetected),
        .stopDetected    (stopDetected),
        .sclRise         (sclRise),
        .sclFall         (sclFall),
        .busBusy         (busBusy),
        .byteData        (byteData),
        .byteValid       (byteValid),
        .byteIsAddress   (byteIsAddress),
        .ackBit          (ackBit),
        .ackValid        (ackValid),
        .frameError      (frameError),
        .busTimeout      (busTimeout),
        .dbgState        (dbgState)
    );

    // ---------------- bookkeeping ----------------
    int n_cmp  = 0;
    int n_fail = 0;
    int seen_start = 0, seen_rep = 0, seen_stop = 0, seen_ferr = 0;
    int seen_ferr_with_stop = 0, seen_to = 0;

    logic [8:0] exp_q[$];      // {isAddress, byte} expected in order
    logic [0:0] exp_ack_q[$];  // expected ACK bits in order

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Works on whole bus events: a list of received bits, a busy flag and
    // whether the next rise is the ACK slot.
    bit         m_prev_scl = 1'b1, m_prev_sda = 1'b1;
    bit         m_busy = 1'b0, m_in_ack = 1'b0, m_addr_next = 1'b0;
    bit         m_bits[$];
    int         m_low = 0;
    logic       e_start, e_rep, e_stop, e_rise, e_fall, e_bv, e_isaddr;
    logic       e_ack, e_ackv, e_ferr, e_to;
    logic [7:0] e_byte;

    task automatic model_reset();
        m_prev_scl = 1'b1; m_prev_sda = 1'b1;
        m_busy = 1'b0; m_in_ack = 1'b0; m_addr_next = 1'b0;
        m_bits.delete(); m_low = 0;
        e_start = 0; e_rep = 0; e_stop = 0; e_rise = 0; e_fall = 0;
        e_bv = 0; e_isaddr = 0; e_ack = 0; e_ackv = 0; e_ferr = 0; e_to = 0;
        e_byte = 8'h00;
    endtask

    task automatic model_step();
        bit is_start, is_stop, is_rise, to_hit;
        int val;
        if (!rst_n) begin
            model_reset();
            return;
        end
        e_start = 0; e_rep = 0; e_stop = 0; e_bv = 0; e_isaddr = 0;
        e_ackv = 0; e_ferr = 0; e_to = 0;
        is_rise  = !m_prev_scl && scl;
        is_start = m_prev_scl && scl && m_prev_sda && !sda;
        is_stop  = m_prev_scl && scl && !m_prev_sda && sda;
        e_rise   = is_rise;
        e_fall   = m_prev_scl && !scl;
        to_hit   = 1'b0;
`ifdef BUS_TIMEOUT_EN
        if (m_busy && !scl) begin
            m_low++;
            if (m_low == TO_LIM) begin
                to_hit = 1'b1;
                m_low  = 0;
            end
        end else begin
            m_low = 0;
        end
`endif
        if (is_start) begin
            e_start = 1; e_rep = m_busy;
            m_busy = 1; m_in_ack = 0; m_addr_next = 1; m_bits.delete();
        end else if (is_stop) begin
            e_stop = 1;
            e_ferr = m_busy && (m_in_ack || m_bits.size() != 0);
            m_busy = 0; m_in_ack = 0; m_bits.delete();
        end else if (to_hit) begin
            e_to = 1; m_busy = 0; m_in_ack = 0; m_bits.delete();
        end else if (is_rise && m_busy) begin
            if (m_in_ack) begin
                e_ack = sda; e_ackv = 1; m_in_ack = 0;
            end else begin
                m_bits.push_back(sda);
                if (m_bits.size() == 8) begin
                    val = 0;
                    foreach (m_bits[i]) val = val * 2 + int'(m_bits[i]);
                    e_byte = val[7:0]; e_bv = 1; e_isaddr = m_addr_next;
                    m_addr_next = 0; m_bits.delete(); m_in_ack = 1;
                end
            end
        end
        m_prev_scl = scl; m_prev_sda = sda;
    endtask

    // ---------------- compare process / scoreboard ----------------
    initial begin
        logic [8:0] eb;
        logic [0:0] ea;
        forever begin
            @(posedge clk);
            model_step();
            #1;
            check("startDetected", startDetected, e_start);
            check("repStartDetected", repStartDetected, e_rep);
            check("stopDetected", stopDetected, e_stop);
            check("sclRise", sclRise, e_rise);
            check("sclFall", sclFall, e_fall);
            check("busBusy", busBusy, m_busy);
            check("byteData", byteData, e_byte);
            check("byteValid", byteValid, e_bv);
            check("byteIsAddress", byteIsAddress, e_isaddr);
            check("ackBit", ackBit, e_ack);
            check("ackValid", ackValid, e_ackv);
            check("frameError", frameError, e_ferr);
            check("busTimeout", busTimeout, e_to);
            if (byteValid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL byte_sb: unexpected byte %0h", byteData);
                end else begin
                    eb = exp_q.pop_front();
                    check("byte_sb", {byteIsAddress, byteData}, eb);
                end
            end
            if (ackValid === 1'b1) begin
                if (exp_ack_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL ack_sb: unexpected ack %0b", ackBit);
                end else begin
                    ea = exp_ack_q.pop_front();
                    check("ack_sb", ackBit, ea);
                end
            end
            if (startDetected === 1'b1) seen_start++;
            if (repStartDetected === 1'b1) seen_rep++;
            if (stopDetected === 1'b1) seen_stop++;
            if (frameError === 1'b1) seen_ferr++;
            if (frameError === 1'b1 && stopDetected === 1'b1) seen_ferr_with_stop++;
            if (busTimeout === 1'b1) seen_to++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input logic s, input logic d, input int n = 1);
        repeat (n) begin
            @(negedge clk);
            scl = s;
            sda = d;
        end
    endtask

    task automatic idle(input int n);
        cyc(1'b1, 1'b1, n);
    endtask

    // From idle (SCL=1, SDA=1): SDA falls, then SCL drops.
    task automatic start_bus();
        cyc(1'b1, 1'b0, 3);
        cyc(1'b0, 1'b0, 2);
    endtask

    // From SCL low: release SDA, raise SCL, drop SDA, drop SCL.
    task automatic rep_start();
        cyc(1'b0, 1'b1, 2);
        cyc(1'b1, 1'b1, 3);
        cyc(1'b1, 1'b0, 3);
        cyc(1'b0, 1'b0, 2);
    endtask

    // From SCL low: SDA low, raise SCL, then raise SDA.
    task automatic stop_bus();
        cyc(1'b0, 1'b0, 2);
        cyc(1'b1, 1'b0, 3);
        cyc(1'b1, 1'b1, 3);
    endtask

    // SDA changes only while SCL is low.
    task automatic send_bit(input logic b);
        cyc(1'b0, b, 2);
        cyc(1'b1, b, 3);
        cyc(1'b0, b, 2);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] v;
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(20);
        check("idle_busy", busBusy, 1'b0);
        check("idle_byte", byteData, 8'h00);
        check("idle_starts", seen_start, 0);

        // address 0xA1 + ACK
        start_bus();
        exp_q.push_back({1'b1, 8'hA1});
        send_byte(8'hA1);
        exp_ack_q.push_back(1'b0);
        send_bit(1'b0);
        check("addr_byte", byteData, 8'hA1);
        check("addr_busy", busBusy, 1'b1);
        check("addr_ack", ackBit, 1'b0);

        // data 0x3C + NACK, repeated START, address 0x55 + ACK
        exp_q.push_back({1'b0, 8'h3C});
        send_byte(8'h3C);
        exp_ack_q.push_back(1'b1);
        send_bit(1'b1);
        check("data_byte", byteData, 8'h3C);
        check("data_nack", ackBit, 1'b1);
        rep_start();
        check("rep_start_cnt", seen_rep, 1);
        exp_q.push_back({1'b1, 8'h55});
        send_byte(8'h55);
        exp_ack_q.push_back(1'b0);
        send_bit(1'b0);
        check("rep_byte", byteData, 8'h55);

        // STOP mid-byte after 3 data bits
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        stop_bus();
        idle(5);
        check("stop_busy", busBusy, 1'b0);
        check("stop_ferr_pair", seen_ferr_with_stop, 1);
        check("stop_byte_held", byteData, 8'h55);

        // simultaneous SCL and SDA fall on an idle bus
        cyc(1'b0, 1'b0);
        @(posedge clk); #1;
        check("simul_fall", sclFall, 1'b1);
        check("simul_no_start", startDetected, 1'b0);
        cyc(1'b1, 1'b1);
        idle(5);

        // STOP in the ACK slot (SCL still high after the 8th rise)
        start_bus();
        v = 8'h5A;
        exp_q.push_back({1'b1, v});
        for (int i = 7; i >= 1; i--) send_bit(v[i]);
        cyc(1'b0, v[0], 2);
        cyc(1'b1, v[0], 3);
        cyc(1'b1, 1'b1, 3);
        idle(3);
        check("ack_stop_ferr", seen_ferr, 2);
        check("ack_stop_byte", byteData, 8'h5A);

        // START directly followed by STOP: no frame error
        cyc(1'b1, 1'b0, 3);
        cyc(1'b1, 1'b1, 3);
        idle(3);
        check("clean_stop_ferr", seen_ferr, 2);
        check("stop_cnt", seen_stop, 3);

        // reset in the middle of a byte
        start_bus();
        send_bit(1'b1); send_bit(1'b1);
        @(negedge clk);
        rst_n = 1'b0; scl = 1'b1; sda = 1'b1;
        @(posedge clk); #1;
        check("rst_busy", busBusy, 1'b0);
        check("rst_byte", byteData, 8'h00);
        check("rst_ack", ackBit, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(5);

`ifdef BUS_TIMEOUT_EN
        start_bus();
        cyc(1'b0, 1'b0, TO_LIM + 10);
        check("to_cnt", seen_to, 1);
        check("to_busy", busBusy, 1'b0);
        cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b1);
        idle(3);
        check("start_cnt", seen_start, 6);
`else
        check("to_cnt", seen_to, 0);
        check("start_cnt", seen_start, 5);
`endif
        check("byte_q_drained", exp_q.size(), 0);
        check("ack_q_drained", exp_ack_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
